// File: rtl/dualport_ram_param_pkg.sv
// Shared types for the parametrised dual-port RAM: sweep controller state encoding.
package dualport_ram_param_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/dualport_ram_param_sweep_ctrl.sv
// Clear-sweep controller: walks every address once after reset or clr, then
// hands the ports back to the user. accept qualifies user reads and writes.
module ram_sweep_ctrl
  import dualport_ram_param_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              init_busy,
  output logic              accept,
  output logic [ADDR_W-1:0] sweep_add
);

  localparam logic [ADDR_W-1:0] LAST_ADD = '1;

  sweep_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Termination is on the last-address compare, so the counter never wraps into RUN early.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADD) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (clr) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign init_busy = (state_reg == INIT);
  assign accept    = (state_reg == RUN) && !clr;
  assign sweep_add = cnt_reg;

endmodule

// File: rtl/dualport_ram_param.sv
// Simple dual-port RAM (one write, one registered read) with hardware clear sweep.
// BYPASS selects write-first (1) or read-first (0) behaviour on same-address collisions.
module dualport_ram_param
  import dualport_ram_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] datain,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_add,
  input  logic              clr,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] sweep_add;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic              bypass_hit;

  ram_sweep_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_sweep (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .init_busy(init_busy),
    .accept   (accept),
    .sweep_add(sweep_add)
  );

  // The sweep owns the write port while busy; otherwise user writes pass when accepted.
  always_comb begin
    ram_we = we && accept;
    ram_wa = wr_add;
    ram_wd = datain;
    if (init_busy) begin
      ram_we = 1'b1;
      ram_wa = sweep_add;
      ram_wd = '0;
    end
  end

  if (BYPASS != 0) begin : g_write_first
    assign bypass_hit = we && (wr_add == rd_add);
  end else begin : g_read_first
    assign bypass_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wa] <= ram_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re && accept;
      if (re && accept) begin
        dataout <= bypass_hit ? datain : mem[rd_add];
      end
    end
  end

endmodule

// File: tb/tb_dualport_ram_param.sv
// Directed bench: write-first and read-first 16x8 instances share stimulus, a 64x16
// instance covers the wider configuration and mid-sweep reset.
module tb_dualport_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, re, clr;
  logic [3:0] wr_add, rd_add;
  logic [7:0] datain;
  logic [7:0] do_a, do_b;
  logic       rv_a, rv_b, busy_a, busy_b;

  logic        rst_c, we_c, re_c, clr_c;
  logic [5:0]  wa_c, ra_c;
  logic [15:0] di_c, do_c;
  logic        rv_c, busy_c;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] mem_m [16];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a, last_b;
  bit         run;

  dualport_ram_param #(.DATA_W(8), .ADDR_W(4), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .wr_add(wr_add), .datain(datain), .re(re),
    .rd_add(rd_add), .clr(clr), .dataout(do_a), .rd_valid(rv_a), .init_busy(busy_a)
  );

  dualport_ram_param #(.DATA_W(8), .ADDR_W(4), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .wr_add(wr_add), .datain(datain), .re(re),
    .rd_add(rd_add), .clr(clr), .dataout(do_b), .rd_valid(rv_b), .init_busy(busy_b)
  );

  dualport_ram_param #(.DATA_W(16), .ADDR_W(6), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst_c), .we(we_c), .wr_add(wa_c), .datain(di_c), .re(re_c),
    .rd_add(ra_c), .clr(clr_c), .dataout(do_c), .rd_valid(rv_c), .init_busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; pops the scoreboard for both shared-stimulus instances.
  task automatic cyc();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("rv_a", 32'(rv_a), 32'd1);
      chk("rd_a", 32'(do_a), 32'(e));
      last_a = e;
      $display("read  A addr=%0d data=%h exp=%h", rd_add, do_a, e);
    end else begin
      chk("idle_rv_a", 32'(rv_a), 32'd0);
      chk("hold_a", 32'(do_a), 32'(last_a));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("rv_b", 32'(rv_b), 32'd1);
      chk("rd_b", 32'(do_b), 32'(e));
      last_b = e;
      $display("read  B addr=%0d data=%h exp=%h", rd_add, do_b, e);
    end else begin
      chk("idle_rv_b", 32'(rv_b), 32'd0);
      chk("hold_b", 32'(do_b), 32'(last_b));
    end
  endtask

  task automatic op(input bit w, input logic [3:0] wa, input logic [7:0] wd,
                    input bit r, input logic [3:0] ra, input bit c);
    we = w; wr_add = wa; datain = wd; re = r; rd_add = ra; clr = c;
    if (run && !c) begin
      if (r) begin
        qa.push_back((w && wa == ra) ? wd : mem_m[ra]);
        qb.push_back(mem_m[ra]);
      end
      if (w) mem_m[wa] = wd;
    end else if (run && c) begin
      run = 0;
      foreach (mem_m[i]) mem_m[i] = 8'h00;
    end
    cyc();
  endtask

  task automatic wait_sweep(input int exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      chk("sweep_rv_a", 32'(rv_a), 32'd0);
      chk("sweep_rv_b", 32'(rv_b), 32'd0);
      chk("sweep_hold_a", 32'(do_a), 32'(last_a));
    end while (busy_a && n < 100);
    chk("sweep_len_a", 32'(n), 32'(exp));
    chk("sweep_done_b", 32'(busy_b), 32'd0);
    $display("sweep done after %0d cycles", n);
    run = 1;
  endtask

  task automatic wait_c(input int exp, input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy_c && n < 200);
    chk(tag, 32'(n), 32'(exp));
    $display("sweep C done after %0d cycles", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
    wr_add = '0; rd_add = '0; datain = '0;
    rst_c = 1'b0; we_c = 1'b0; re_c = 1'b0; clr_c = 1'b0;
    wa_c = '0; ra_c = '0; di_c = '0;
    last_a = 8'h00; last_b = 8'h00; run = 0;
    foreach (mem_m[i]) mem_m[i] = 8'h00;

    @(posedge clk);
    #1;
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_do_a", 32'(do_a), 32'd0);
    chk("rst_rv_a", 32'(rv_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_busy_c", 32'(busy_c), 32'd1);
    chk("rst_do_c", 32'(do_c), 32'd0);

    // Release reset with garbage traffic and clr held; all must be ignored by the sweep.
    rst = 1'b1;
    we = 1'b1; wr_add = 4'd9; datain = 8'hEE; re = 1'b1; rd_add = 4'd9; clr = 1'b1;
    wait_sweep(16);

    op(0, 4'd0, 8'h00, 1, 4'd9, 0);
    op(0, 4'd0, 8'h00, 0, 4'd0, 0);

    op(1, 4'd3, 8'hA5, 0, 4'd0, 0);
    op(0, 4'd0, 8'h00, 1, 4'd3, 0);
    op(0, 4'd0, 8'h00, 0, 4'd0, 0);
    op(0, 4'd0, 8'h00, 0, 4'd0, 0);

    op(1, 4'd5, 8'h11, 0, 4'd0, 0);
    op(1, 4'd5, 8'h3C, 1, 4'd5, 0);
    op(0, 4'd0, 8'h00, 1, 4'd5, 0);

    op(1, 4'd7, 8'h42, 0, 4'd0, 0);
    op(1, 4'd2, 8'h77, 1, 4'd7, 0);
    op(0, 4'd0, 8'h00, 1, 4'd2, 0);

    for (int i = 0; i < 16; i++) op(1, 4'(i), 8'hFF, 0, 4'd0, 0);
    op(0, 4'd0, 8'h00, 1, 4'd4, 0);

    op(1, 4'd4, 8'h99, 1, 4'd4, 1);
    chk("clr_busy_a", 32'(busy_a), 32'd1);
    chk("clr_busy_b", 32'(busy_b), 32'd1);
    we = 1'b1; wr_add = 4'd4; datain = 8'h99; re = 1'b1; rd_add = 4'd4; clr = 1'b1;
    wait_sweep(16);

    for (int i = 0; i < 16; i++) op(0, 4'd0, 8'h00, 1, 4'(i), 0);
    op(0, 4'd0, 8'h00, 0, 4'd0, 0);

    // Wide configuration: full sweep, then reset mid-read and mid-sweep.
    rst_c = 1'b1;
    wait_c(64, "c_first_sweep");
    we_c = 1'b1; wa_c = 6'd63; di_c = 16'hBEEF;
    @(posedge clk); #1;
    we_c = 1'b0; re_c = 1'b1; ra_c = 6'd63;
    @(posedge clk); #1;
    re_c = 1'b0;
    chk("c_rv_pre", 32'(rv_c), 32'd1);
    chk("c_do_pre", 32'(do_c), 32'hBEEF);
    #2 rst_c = 1'b0;
    #1;
    chk("c_async_busy", 32'(busy_c), 32'd1);
    chk("c_async_rv", 32'(rv_c), 32'd0);
    chk("c_async_do", 32'(do_c), 32'd0);
    @(posedge clk); #1;
    rst_c = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    chk("c_mid_busy", 32'(busy_c), 32'd1);
    rst_c = 1'b0;
    #1;
    chk("c_mid_rst_busy", 32'(busy_c), 32'd1);
    chk("c_mid_rst_do", 32'(do_c), 32'd0);
    @(posedge clk); #1;
    rst_c = 1'b1;
    wait_c(64, "c_restart_sweep");

    re_c = 1'b1; ra_c = 6'd63;
    @(posedge clk); #1;
    re_c = 1'b0;
    chk("c_rv_63_clr", 32'(rv_c), 32'd1);
    chk("c_do_63_clr", 32'(do_c), 32'd0);
    we_c = 1'b1; wa_c = 6'd63; di_c = 16'hBEEF;
    @(posedge clk); #1;
    we_c = 1'b0; re_c = 1'b1; ra_c = 6'd63;
    @(posedge clk); #1;
    re_c = 1'b0;
    chk("c_rv_63", 32'(rv_c), 32'd1);
    chk("c_do_63", 32'(do_c), 32'hBEEF);
    $display("read  C addr=63 data=%h", do_c);
    @(posedge clk); #1;
    chk("c_rv_drop", 32'(rv_c), 32'd0);
    chk("c_do_hold", 32'(do_c), 32'hBEEF);
    re_c = 1'b1; ra_c = 6'd0;
    @(posedge clk); #1;
    re_c = 1'b0;
    chk("c_rv_0", 32'(rv_c), 32'd1);
    chk("c_do_0", 32'(do_c), 32'd0);
    $display("read  C addr=0 data=%h", do_c);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
